// File: rtl/viterbi_tbu.sv
// Traceback unit for a 4-state (K=3) hard-decision Viterbi decoder.
// Optional macro TBU_MINSEL_EN selects the minimum-PM start state; otherwise traceback starts at state 0.
module viterbi_tbu #(
    parameter int TBL      = 15,
    parameter int PM_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    output logic                    busy_o,
    input  logic [PM_WIDTH-1:0]     pm_current_s0_i,
    input  logic [PM_WIDTH-1:0]     pm_current_s1_i,
    input  logic [PM_WIDTH-1:0]     pm_current_s2_i,
    input  logic [PM_WIDTH-1:0]     pm_current_s3_i,
    input  logic [3:0]              pm_read_data_i,
    output logic [$clog2(TBL)-1:0]  pm_read_addr_o,
    output logic                    data_serial_o,
    output logic                    valid_serial_o
);
    localparam int AW = $clog2(TBL);
    localparam int CW = $clog2(TBL + 1);

    // state | meaning
    // IDLE  | waiting for a warm trigger; read address follows the write pointer
    // READ  | decision address presented to the PMU memory
    // STEP  | decision word valid; move one trellis step back
    // DONE  | decoded bit presented with its strobe
    typedef enum logic [1:0] {IDLE, READ, STEP, DONE} fsm_t;

    fsm_t            fsm_q, fsm_d;
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   step_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      st_q;
    logic            data_q;
    logic            vout_q;

    logic            warm;
    logic            trigger;
    logic            last_step;
    logic [1:0]      start_st;
    logic [1:0]      st_pred;

    assign warm      = (cnt_q == CW'(TBL));
    assign trigger   = valid_i & warm & (fsm_q == IDLE);
    assign last_step = (step_q == AW'(TBL - 1));
    assign st_pred   = {st_q[0], pm_read_data_i[st_q]};

`ifdef TBU_MINSEL_EN
    logic [PM_WIDTH-1:0] best_pm;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        start_st = 2'd0;
        best_pm  = pm_current_s0_i;
        if (pm_current_s1_i < best_pm) begin
            start_st = 2'd1;
            best_pm  = pm_current_s1_i;
        end
        if (pm_current_s2_i < best_pm) begin
            start_st = 2'd2;
            best_pm  = pm_current_s2_i;
        end
        if (pm_current_s3_i < best_pm) begin
            start_st = 2'd3;
            best_pm  = pm_current_s3_i;
        end
    end
`else
    logic pm_unused;

    assign pm_unused = ^{pm_current_s0_i, pm_current_s1_i, pm_current_s2_i, pm_current_s3_i};
    assign start_st  = 2'd0;
`endif

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (trigger) fsm_d = READ;
            READ:    fsm_d = STEP;
            STEP:    fsm_d = last_step ? DONE : READ;
            DONE:    fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= IDLE;
            wptr_q <= '0;
            addr_q <= '0;
            step_q <= '0;
            cnt_q  <= '0;
            st_q   <= 2'd0;
            data_q <= 1'b0;
            vout_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            vout_q <= 1'b0;
            // Pointer and warm-up counter track the PMU regardless of FSM state.
            if (valid_i) begin
                wptr_q <= (wptr_q == AW'(TBL - 1)) ? '0 : wptr_q + AW'(1);
                if (!warm) cnt_q <= cnt_q + CW'(1);
            end
            case (fsm_q)
                IDLE: begin
                    if (trigger) begin
                        st_q   <= start_st;
                        addr_q <= wptr_q;
                        step_q <= '0;
                    end
                end
                STEP: begin
                    st_q   <= st_pred;
                    addr_q <= (addr_q == '0) ? AW'(TBL - 1) : addr_q - AW'(1);
                    step_q <= step_q + AW'(1);
                    // Register the final state's bit so it is stable during DONE.
                    if (last_step) begin
                        data_q <= st_pred[1];
                        vout_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pm_read_addr_o = (fsm_q == IDLE) ? wptr_q : addr_q;
    assign busy_o         = (fsm_q != IDLE) | trigger;
    assign data_serial_o  = data_q;
    assign valid_serial_o = vout_q;

endmodule

// File: tb/tb_viterbi_tbu.sv
// Directed scoreboard bench for viterbi_tbu: expected bits are queued at trigger and popped by an output monitor.
module tb_viterbi_tbu;
    localparam int TBL = 15;
    localparam int PMW = 8;
    localparam int AW  = $clog2(TBL);

    logic           clk;
    logic           rst;
    logic           valid_i;
    logic           busy;
    logic [PMW-1:0] pm0, pm1, pm2, pm3;
    logic [3:0]     pm_read_data;
    logic [AW-1:0]  pm_read_addr;
    logic           data_serial;
    logic           valid_serial;

    viterbi_tbu #(.TBL(TBL), .PM_WIDTH(PMW)) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_i         (valid_i),
        .busy_o          (busy),
        .pm_current_s0_i (pm0),
        .pm_current_s1_i (pm1),
        .pm_current_s2_i (pm2),
        .pm_current_s3_i (pm3),
        .pm_read_data_i  (pm_read_data),
        .pm_read_addr_o  (pm_read_addr),
        .data_serial_o   (data_serial),
        .valid_serial_o  (valid_serial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PMU decision memory with one-cycle read latency.
    logic [3:0] mem [TBL];
    always @(posedge clk) pm_read_data <= mem[pm_read_addr];

    int n_vec = 0;
    int n_err = 0;
    bit exp_q[$];
    int wptr_m = 0;
    int cnt_m  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid_serial === 1'b1) begin
            bit e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL spurious_output: got valid_serial_o=1, expected no output");
            end else begin
                e = exp_q.pop_front();
                if (data_serial !== e) begin
                    n_err++;
                    $display("FAIL data_serial: got %0b, expected %0b", data_serial, e);
                end
            end
        end
    end

    task automatic advance_model();
        wptr_m = (wptr_m + 1) % TBL;
        if (cnt_m < TBL) cnt_m++;
    endtask

    task automatic fill(input logic [3:0] word);
        for (int i = 0; i < TBL; i++) mem[i] = word;
    endtask

    // One valid_i pulse issued from IDLE, followed by one quiet cycle.
    task automatic pulse(input bit exp_busy, input string name);
        @(negedge clk);
        valid_i = 1'b1;
        #1;
        check({name, "_busy"}, busy, exp_busy);
        check({name, "_addr_idle"}, pm_read_addr, wptr_m);
        advance_model();
        @(negedge clk);
        valid_i = 1'b0;
    endtask

    task automatic warmup(input string name);
        for (int i = 0; i < TBL; i++) pulse(1'b0, name);
    endtask

    task automatic traceback(input logic [3:0] word, input int p0, input int p1, input int p2,
                             input int p3, input bit exp_bit, input int mid_k, input string name);
        int w0;
        fill(word);
        pm0 = PMW'(p0); pm1 = PMW'(p1); pm2 = PMW'(p2); pm3 = PMW'(p3);
        exp_q.push_back(exp_bit);
        w0 = wptr_m;
        pulse(1'b1, name);
        for (int k = 0; k < TBL; k++) begin
            if (k > 0) begin
                @(negedge clk);
                valid_i = 1'b0;
                @(negedge clk);
            end
            check({name, "_rd_addr"}, pm_read_addr, (w0 - k + TBL) % TBL);
            if (k == mid_k) begin
                valid_i = 1'b1;
                #1;
                check({name, "_busy_mid"}, busy, 1);
                advance_model();
            end
        end
        @(negedge clk);
        valid_i = 1'b0;
        check({name, "_busy_step"}, busy, 1);
        @(negedge clk);
        check({name, "_valid_done"}, valid_serial, 1);
        @(negedge clk);
        check({name, "_valid_after"}, valid_serial, 0);
        check({name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0;
        pm0 = '0; pm1 = '0; pm2 = '0; pm3 = '0;
        fill(4'b0000);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid_serial, 0);
        check("rst_data", data_serial, 0);
        check("rst_addr", pm_read_addr, 0);
        @(negedge clk);
        rst = 1'b0;

        warmup("warm");
        // A: all-zero decisions from state 0 -> bit 0; addresses wrap 0 -> 14.
        traceback(4'b0000, 0, 255, 255, 255, 1'b0, -1, "vec_a");
        // B: all-one decisions converge to state 3 -> bit 1.
        traceback(4'b1111, 255, 255, 255, 0, 1'b1, -1, "vec_b");
        // C: 0011 cycles 1,3,2,0 (period 4); start 1 lands on 0, start 0 lands on 2.
`ifdef TBU_MINSEL_EN
        traceback(4'b0011, 200, 10, 10, 200, 1'b0, 5, "vec_c");
`else
        traceback(4'b0011, 200, 10, 10, 200, 1'b1, 5, "vec_c");
`endif
        // D: start 0 on 0011 -> state 2 -> bit 1; first address reflects the extra mid pulse.
        traceback(4'b0011, 0, 255, 255, 255, 1'b1, -1, "vec_d");
        repeat (3) @(negedge clk);
        check("data_hold", data_serial, 1);

        // Abort a traceback with reset.
        fill(4'b1111);
        pulse(1'b1, "rst_trig");
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", valid_serial, 0);
        check("abort_data", data_serial, 0);
        check("abort_addr", pm_read_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        wptr_m = 0;
        cnt_m  = 0;
        warmup("rewarm");
        traceback(4'b0011, 0, 255, 255, 255, 1'b1, -1, "vec_e");

        repeat (4) @(negedge clk);
        check("pending_outputs", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/viterbi_tbu.md
Name: viterbi_tbu

Overview:
Traceback unit of a 4-state (K=3) hard-decision Viterbi decoder.
- Sits after the path-metric unit (PMU), which stores one 4-bit survivor-decision word per trellis step in a TBL-deep circular memory.
- On each trellis step, after a TBL-sample warm-up, it picks the best current state and walks TBL steps back through the PMU memory.
- It emits one decoded bit per traceback on a serial output with a valid strobe.

Parameters:
TBL, 15, traceback length = depth of the PMU decision memory (>=2).
PM_WIDTH, 8, width of each path metric (unsigned).

Ports:
clk  in  1  clock, all state updates on rising edge.
rst  in  1  asynchronous, active-high reset.
valid_i  in  1  one-cycle strobe: PMU has written one new decision word this cycle.
busy_o  out  1  traceback in progress; upstream must not assert valid_i while high.
pm_current_s0_i..pm_current_s3_i  in  PM_WIDTH each  current path metrics of states 0..3.
pm_read_data_i  in  4  decision word from PMU memory; bit s = decision of state s; valid 1 cycle after address.
pm_read_addr_o  out  $clog2(TBL)  read address into PMU decision memory.
data_serial_o  out  1  decoded bit.
valid_serial_o  out  1  one-cycle strobe qualifying data_serial_o.

Behaviour:
- Reset (async, rst=1): FSM=IDLE; write pointer, sample counter, step counter, traceback address and state register = 0; data_serial_o=0, valid_serial_o=0; pm_read_addr_o=0.
- Write pointer wptr mirrors the PMU write address:
  - Each valid_i increments wptr modulo TBL (TBL-1 wraps to 0).
  - This applies in every FSM state, so the pointer stays aligned with the PMU.
- Sample counter saturates at TBL. warm = (count==TBL).
  - With default TBL, the first 15 valid_i pulses only fill; the 16th starts traceback.
- busy_o = (FSM != IDLE) | (valid_i & warm & FSM==IDLE). This is combinational, so it rises in the same cycle as the triggering valid_i.
- State encoding s[1:0]:
  - Forward transition: next = {u, s[1]}.
  - Predecessor of s: {s[0], pm_read_data_i[s]}.
  - Decoded bit of a state = s[1].
- FSM:
  - IDLE: pm_read_addr_o = wptr.
    - On valid_i & warm, latch the start state and set addr = wptr (the newest word, written this cycle), step=0, then go to READ.
    - Start state = index of the minimum of the four PMs. Ties go to the lowest index (strict < compare, order s0,s1,s2,s3).
  - READ: drive pm_read_addr_o = addr, then go to STEP.
  - STEP: the read data is valid.
    - state <= {state[0], pm_read_data_i[state]}.
    - addr <= (addr==0) ? TBL-1 : addr-1.
    - step <= step+1.
    - If step==TBL-1, go to DONE; else go to READ.
  - DONE: data_serial_o <= state[1]; valid_serial_o high for exactly this cycle; next IDLE.
- Latency: valid_serial_o is high in the cycle after the 2*TBL-th rising edge following the trigger edge. busy_o falls one cycle after valid_serial_o, provided valid_i is low.
- data_serial_o holds its last value between strobes.
- valid_i while busy: wptr and count advance; no retrigger; that sample produces no output.
- Reset mid-traceback: abort immediately, return to IDLE; warm-up restarts from zero.
- All address arithmetic is modulo TBL, including non-power-of-two TBL.

Optional Feature:
Macro TBU_MINSEL_EN.
- Defined: start state = minimum-PM state as above.
- Undefined: the start state is always 0 and the PM inputs are ignored. This variant is for terminated/zero-tail streams and saves the comparators.

Test Plan:
- Reset, then 15 valid_i pulses spaced 2 cycles apart -> busy_o stays 0, valid_serial_o stays 0.
- Memory all 4'b0000, PMs s0=0, s1..s3=255, 16th valid_i -> busy_o=1 within the same cycle; valid_serial_o pulses 2*TBL+1 cycles later with data_serial_o=0; busy_o=0 on the next cycle.
- Memory all 4'b1111, PM s3 minimum (s3=0, others 255) -> traceback stays in state 3; data_serial_o=1.
- Tie s1=s2=10, s0=s3=200 (TBU_MINSEL_EN) -> start state 1. Verify the first pm_read_addr_o equals wptr, then decrements with wrap 0->14.
- valid_i asserted mid-traceback -> no second output for that pulse; wptr still advances (next trigger's first address = previous +2).
- rst asserted mid-traceback -> outputs 0 immediately; 15 new warm-up samples are required before the next output.
